tiny_soc_mem_xbar: RTL and testbench

Parametrised multi-port memory front-end for the tiny SoC. It replaces a tied-high grant and a single fixed-latency word memory with three pieces of behaviour:
- N Ibex-style requestor ports arbitrated round-robin onto one word-addressed backing array;
- configurable response latency, with up to one new transaction per cycle in flight;
- address-window checking with error responses.

Instruction fetch and LSU traffic of the core, plus a debug/loader port, attach here.

---
 rtl/tiny_soc_mem_xbar.sv | 123 ++++++++++++
 tb/tb_tiny_soc_mem_xbar.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_soc_mem_xbar.sv
// Round-robin multi-port front-end onto a single word-addressed backing array,
// with address-window checking and a fixed-latency response pipeline.
module tiny_soc_mem_xbar #(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned Depth     = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Latency   = 1,
    parameter logic [31:0] BaseAddr  = 32'h8000_0000
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumPorts-1:0]               req_i,
    output logic [NumPorts-1:0]               gnt_o,
    input  logic [NumPorts*32-1:0]            addr_i,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] be_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [NumPorts*DataWidth-1:0]     rdata_o,
    output logic [NumPorts-1:0]               err_o
);

    localparam int unsigned BeW     = DataWidth / 8;
    localparam int unsigned OffW    = $clog2(BeW);
    localparam int unsigned IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [32:0] EndAddr = 33'(BaseAddr) + 33'(Depth * BeW);

    typedef struct packed {
        logic                 valid;
        logic [PtrW-1:0]      port;
        logic                 err;
        logic [DataWidth-1:0] data;
    } stage_t;

    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [PtrW-1:0]      sel;
    logic                 any_gnt;
    int unsigned          cand;
    logic [31:0]          s_addr;
    logic                 s_we;
    logic [BeW-1:0]       s_be;
    logic [DataWidth-1:0] s_wdata;
    logic                 in_range;
    logic [31:0]          offset;
    logic [IdxW-1:0]      widx;
    logic                 acc_wr, acc_rd;
    logic [DataWidth-1:0] mem_q [Depth];
    stage_t               stage_d;
    stage_t               pipe_q [Latency];

    // Round-robin pick: first requester at or after the pointer; nothing granted in reset
    always_comb begin
        sel     = '0;
        any_gnt = 1'b0;
        gnt_o   = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = (32'(ptr_q) + i) % NumPorts;
            if (!any_gnt && rst_ni && req_i[PtrW'(cand)]) begin
                any_gnt = 1'b1;
                sel     = PtrW'(cand);
            end
        end
        if (any_gnt) gnt_o[sel] = 1'b1;
        ptr_d = ptr_q;
        if (any_gnt) ptr_d = (32'(sel) == NumPorts - 1) ? '0 : PtrW'(32'(sel) + 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign s_addr   = addr_i[32*32'(sel) +: 32];
    assign s_we     = we_i[sel];
    assign s_be     = be_i[BeW*32'(sel) +: BeW];
    assign s_wdata  = wdata_i[DataWidth*32'(sel) +: DataWidth];
    assign in_range = (33'(s_addr) >= 33'(BaseAddr)) && (33'(s_addr) < EndAddr);
    assign offset   = s_addr - BaseAddr;
    assign widx     = IdxW'(offset >> OffW);
    assign acc_wr   = any_gnt & s_we & in_range;
    assign acc_rd   = any_gnt & ~s_we & in_range;

    // Backing array is deliberately not reset; reads see pre-edge contents
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            for (int unsigned b = 0; b < BeW; b++) begin
                if (s_be[b]) mem_q[widx][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        stage_d       = '0;
        stage_d.valid = any_gnt;
        stage_d.port  = sel;
        stage_d.err   = any_gnt & ~in_range;
        stage_d.data  = acc_rd ? mem_q[widx] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Latency; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int unsigned i = 1; i < Latency; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Route the last stage to its owning port only
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        if (pipe_q[Latency-1].valid) begin
            rvalid_o[pipe_q[Latency-1].port] = 1'b1;
            err_o[pipe_q[Latency-1].port]    = pipe_q[Latency-1].err;
            rdata_o[DataWidth*32'(pipe_q[Latency-1].port) +: DataWidth] = pipe_q[Latency-1].data;
        end
    end

endmodule

// File: tb/tb_tiny_soc_mem_xbar.sv
// Scoreboard bench for tiny_soc_mem_xbar: per-port request queues feed a driver,
// expected responses are queued on grant and checked by an independent monitor.
module tb_tiny_soc_mem_xbar;

    localparam int NP  = 3;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LAT = 4;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [2:0] RR_EXP [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NP-1:0]      req_i;
    logic [NP-1:0]      gnt_o;
    logic [NP*32-1:0]   addr_i;
    logic [NP-1:0]      we_i;
    logic [NP*BW-1:0]   be_i;
    logic [NP*DW-1:0]   wdata_i;
    logic [NP-1:0]      rvalid_o;
    logic [NP*DW-1:0]   rdata_o;
    logic [NP-1:0]      err_o;

    tiny_soc_mem_xbar #(
        .NumPorts (NP),
        .Depth    (DEPTH),
        .DataWidth(DW),
        .Latency  (LAT),
        .BaseAddr (BASE)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o)
    );

    txn_t          tq [NP][$];
    exp_t          sb [NP][$];
    logic [NP-1:0] glog [$];
    int            mptr;
    int            cyc;
    int            checks;
    int            errors;
    int            ek;
    logic [NP-1:0] eg;
    exp_t          de;
    exp_t          me;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        txn_t t;
        t.addr = a; t.we = we; t.be = be; t.wdata = wd; t.exp_data = ed; t.exp_err = ee;
        tq[p].push_back(t);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk); #1;
            done = 1'b1;
            for (int p = 0; p < NP; p++)
                if (tq[p].size() != 0 || sb[p].size() != 0) done = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: traffic still pending after 300 cycles");
        end
    endtask

    // Driver: present queue heads, check grant against round-robin model, queue expectations
    initial begin
        req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
        mptr = 0;
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                if (tq[p].size() > 0) begin
                    req_i[p]            = 1'b1;
                    addr_i[p*32 +: 32]  = tq[p][0].addr;
                    we_i[p]             = tq[p][0].we;
                    be_i[p*BW +: BW]    = tq[p][0].be;
                    wdata_i[p*DW +: DW] = tq[p][0].wdata;
                end else begin
                    req_i[p] = 1'b0;
                end
            end
            @(negedge clk);
            eg = '0;
            ek = -1;
            if (rst_n) begin
                for (int i = 0; i < NP; i++)
                    if (ek < 0 && req_i[(mptr + i) % NP]) ek = (mptr + i) % NP;
            end
            if (ek >= 0) eg[ek] = 1'b1;
            checks++;
            if (gnt_o !== eg) begin
                errors++;
                $display("FAIL grant: got %b expected %b (cycle %0d)", gnt_o, eg, cyc);
            end
            if (ek >= 0) mptr = (ek + 1) % NP;
            if (rst_n && req_i != '0) glog.push_back(gnt_o);
            for (int p = 0; p < NP; p++) begin
                if (gnt_o[p] && req_i[p] && tq[p].size() > 0) begin
                    de.data = tq[p][0].exp_data;
                    de.err  = tq[p][0].exp_err;
                    de.due  = cyc + LAT;
                    sb[p].push_back(de);
                    void'(tq[p].pop_front());
                end
            end
        end
    end

    // Monitor: compare every presented response against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int p = 0; p < NP; p++) begin
                    if (rvalid_o[p]) begin
                        checks++;
                        if (sb[p].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_rvalid port%0d: data %h err %b (cycle %0d)",
                                     p, rdata_o[p*DW +: DW], err_o[p], cyc);
                        end else begin
                            me = sb[p].pop_front();
                            if (rdata_o[p*DW +: DW] !== me.data || err_o[p] !== me.err || cyc != me.due) begin
                                errors++;
                                $display("FAIL resp port%0d: got data %h err %b cycle %0d, expected data %h err %b cycle %0d",
                                         p, rdata_o[p*DW +: DW], err_o[p], cyc, me.data, me.err, me.due);
                            end
                        end
                    end else begin
                        checks++;
                        if (rdata_o[p*DW +: DW] !== '0 || err_o[p] !== 1'b0) begin
                            errors++;
                            $display("FAIL idle_port%0d: data %h err %b while rvalid low", p,
                                     rdata_o[p*DW +: DW], err_o[p]);
                        end
                        if (sb[p].size() > 0 && sb[p][0].due < cyc) begin
                            checks++;
                            errors++;
                            $display("FAIL missing_resp port%0d: expected at cycle %0d, now %0d",
                                     p, sb[p][0].due, cyc);
                            void'(sb[p].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        #12;
        chk("reset_gnt", gnt_o, '0);
        chk("reset_rvalid", rvalid_o, '0);
        chk("reset_rdata", rdata_o, '0);
        chk("reset_err", err_o, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Full write, byte-0 merge, readback, then unaligned address of the same word
        push(0, 32'h8000_0010, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        push(0, 32'h8000_0010, 1'b1, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0);
        push(0, 32'h8000_0010, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEAA, 1'b0);
        push(0, 32'h8000_0013, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEAA, 1'b0);
        wait_idle();

        // Address window edges
        push(0, BASE,           1'b1, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
        push(0, 32'h7FFF_FFFC,  1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        push(0, BASE + 32'd256, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        push(0, BASE + 32'd256, 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
        push(0, BASE,           1'b0, 4'b0000, 32'h0, 32'h1234_5678, 1'b0);
        push(0, BASE + 32'd252, 1'b1, 4'b1111, 32'h0A0B_0C0D, 32'h0, 1'b0);
        push(0, BASE + 32'd252, 1'b0, 4'b0000, 32'h0, 32'h0A0B_0C0D, 1'b0);
        wait_idle();

        // Byte-lane 2 merge on port 2 (leaves pointer at 0)
        push(2, BASE + 32'd8, 1'b1, 4'b1111, 32'h1122_3344, 32'h0, 1'b0);
        push(2, BASE + 32'd8, 1'b1, 4'b0100, 32'h00FF_0000, 32'h0, 1'b0);
        push(2, BASE + 32'd8, 1'b0, 4'b0000, 32'h0, 32'h11FF_3344, 1'b0);
        wait_idle();

        // All ports requesting for six cycles
        glog.delete();
        push(0, BASE + 32'd40, 1'b1, 4'b1111, 32'hA0A0_A0A0, 32'h0, 1'b0);
        push(0, BASE + 32'd40, 1'b0, 4'b0000, 32'h0, 32'hA0A0_A0A0, 1'b0);
        push(1, BASE + 32'd44, 1'b1, 4'b1111, 32'hB1B1_B1B1, 32'h0, 1'b0);
        push(1, BASE + 32'd44, 1'b0, 4'b0000, 32'h0, 32'hB1B1_B1B1, 1'b0);
        push(2, BASE + 32'd48, 1'b1, 4'b1111, 32'hC2C2_C2C2, 32'h0, 1'b0);
        push(2, BASE + 32'd48, 1'b0, 4'b0000, 32'h0, 32'hC2C2_C2C2, 1'b0);
        wait_idle();
        chk("rr_count", 128'(glog.size()), 128'd6);
        for (int i = 0; i < 6; i++)
            if (i < glog.size()) chk($sformatf("rr_gnt%0d", i), glog[i], RR_EXP[i]);

        // Write then four back-to-back reads of word 5 on port 1
        push(1, BASE + 32'd20, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            push(1, BASE + 32'd20, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        wait_idle();

        // Reset with two reads in flight, the first one currently presented
        push(0, BASE + 32'd40, 1'b0, 4'b0000, 32'h0, 32'hA0A0_A0A0, 1'b0);
        push(0, BASE + 32'd44, 1'b0, 4'b0000, 32'h0, 32'hB1B1_B1B1, 1'b0);
        for (int i = 0; i < 50 && tq[0].size() != 0; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("inflight_rvalid", rvalid_o, 3'b001);
        rst_n = 1'b0;
        #1;
        chk("midreset_gnt", gnt_o, '0);
        chk("midreset_rvalid", rvalid_o, '0);
        chk("midreset_rdata", rdata_o, '0);
        chk("midreset_err", err_o, '0);
        for (int p = 0; p < NP; p++) sb[p].delete();
        mptr = 0;
        push(2, BASE + 32'd48, 1'b0, 4'b0000, 32'h0, 32'hC2C2_C2C2, 1'b0);
        @(negedge clk); #1;
        chk("gnt_held_in_reset", gnt_o, '0);
        push(0, BASE + 32'd40, 1'b0, 4'b0000, 32'h0, 32'hA0A0_A0A0, 1'b0);
        push(1, BASE + 32'd44, 1'b0, 4'b0000, 32'h0, 32'hB1B1_B1B1, 1'b0);
        glog.delete();
        rst_n = 1'b1;
        wait_idle();
        chk("post_reset_first_gnt", (glog.size() > 0) ? glog[0] : 3'b000, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
